// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Contents: operation encoding, FSM state encoding, default width and iteration count.
package muldiv_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITER  = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIXUP,
        MD_DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Datapath-side bus of the multiply/divide unit.
// Issue: start, op, porta, portb. HI/LO direct writes: hi_wen, lo_wen, wdata.
// Status/results: busy, done, dz_flag, hi, lo.
// Modport md is the unit itself, modport tb is whoever drives it.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    import muldiv_unit_pkg::*;

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] porta;
    logic [WIDTH-1:0] portb;
    logic             hi_wen;
    logic             lo_wen;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz_flag;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport md (
        input  start, op, porta, portb, hi_wen, lo_wen, wdata,
        output busy, done, dz_flag, hi, lo
    );

    modport tb (
        output start, op, porta, portb, hi_wen, lo_wen, wdata,
        input  busy, done, dz_flag, hi, lo
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Ports: CLK, nRST (synchronous, active-low), bus (muldiv_unit_if.md):
//   start/op/porta/portb issue an operation, hi_wen/lo_wen/wdata write HI/LO when idle,
//   busy/done/dz_flag report status, hi/lo expose the registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITER  = MD_ITER
) (
    input  logic    CLK,
    input  logic    nRST,
    muldiv_unit_if.md bus
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned ACC_W = 2 * WIDTH;

    // Two's-complement negate when n is set (operand magnitudes and result fixup).
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
        return n ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [ACC_W-1:0] cond_neg_wide(input logic [ACC_W-1:0] x, input logic n);
        return n ? (~x + ACC_W'(1)) : x;
    endfunction

    muldiv_state_t    state;
    muldiv_op_t       op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [ACC_W-1:0] acc;
    logic             neg_res;
    logic             neg_rem;
    logic             dz_pend;
    logic             busy;
    logic             done;
    logic             dz_flag;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Issue-time decode of the incoming operation.
    logic             signed_c;
    logic             is_div_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;

    always_comb begin
        signed_c = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        is_div_c = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
        a_neg_c  = signed_c && bus.porta[WIDTH-1];
        b_neg_c  = signed_c && bus.portb[WIDTH-1];
        a_mag_c  = cond_neg(bus.porta, a_neg_c);
        b_mag_c  = cond_neg(bus.portb, b_neg_c);
    end

    // One CALC iteration. Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc = {remainder, dividend bits still to shift / quotient bits shifted in}.
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_trial_c;
    logic [WIDTH:0]   div_diff_c;
    logic [ACC_W-1:0] acc_step_c;

    always_comb begin
        mul_sum_c   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_trial_c = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
        div_diff_c  = div_trial_c - {1'b0, b_mag};
        acc_step_c  = acc;
        if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
            // Borrow clear means the divisor fit: keep the difference, shift in a 1.
            if (!div_diff_c[WIDTH]) begin
                acc_step_c = {div_diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_c = {div_trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step_c = {mul_sum_c, acc[WIDTH-1:1]};
        end
    end

    // Control FSM, datapath registers and HI/LO.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= MD_IDLE;
            op_q    <= MD_MULT;
            cnt     <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_pend <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz_flag <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_mag   <= a_mag_c;
                        b_mag   <= b_mag_c;
                        neg_res <= a_neg_c ^ b_neg_c;
                        neg_rem <= a_neg_c;
                        dz_flag <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        if (is_div_c && (bus.portb == '0)) begin
                            // Park the raw dividend where FIXUP expects the remainder.
                            dz_pend <= 1'b1;
                            acc     <= {bus.porta, {WIDTH{1'b0}}};
                            state   <= MD_FIXUP;
                        end else begin
                            dz_pend <= 1'b0;
                            acc     <= is_div_c ? {{WIDTH{1'b0}}, a_mag_c}
                                                : {{WIDTH{1'b0}}, b_mag_c};
                            state   <= MD_CALC;
                        end
                    end else begin
                        if (bus.hi_wen) hi <= bus.wdata;
                        if (bus.lo_wen) lo <= bus.wdata;
                    end
                end
                MD_CALC: begin
                    acc <= acc_step_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= MD_FIXUP;
                    end
                end
                MD_FIXUP: begin
                    if (dz_pend) begin
                        hi      <= acc[ACC_W-1:WIDTH];
                        lo      <= '1;
                        dz_flag <= 1'b1;
                    end else if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
                        hi <= cond_neg(acc[ACC_W-1:WIDTH], neg_rem);
                        lo <= cond_neg(acc[WIDTH-1:0], neg_res);
                    end else begin
                        {hi, lo} <= cond_neg_wide(acc, neg_res);
                    end
                    done  <= 1'b1;
                    state <= MD_DONE;
                end
                MD_DONE: begin
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.dz_flag = dz_flag;
    assign bus.hi      = hi;
    assign bus.lo      = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {dz, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input muldiv_op_t o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        logic [31:0] uq;
        logic [31:0] ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MD_MULT: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            MD_DIV: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {1'b0, ur, uq};
            end
        endcase
    endfunction

    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        bus.start = 1'b1;
        bus.op    = o;
        bus.porta = a;
        bus.portb = b;
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    // Sample-by-sample wait for done (bounded); n = cycles since issue edge.
    task automatic wait_done(output int n, output int bcnt);
        n    = 1;
        bcnt = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge CLK);
            n++;
        end
        if (bus.busy === 1'b1) bcnt++;
    endtask

    task automatic run_check(input string tag, input muldiv_op_t o, input logic [31:0] a,
                             input logic [31:0] b);
        logic [64:0] m;
        int          n;
        int          bcnt;
        int          lat;
        m   = model(o, a, b);
        lat = m[64] ? 2 : 34;
        issue(o, a, b);
        wait_done(n, bcnt);
        chk({tag, " done"},    64'(bus.done), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busycnt"}, 64'(bcnt), 64'(lat));
        chk({tag, " hi"},      64'(bus.hi), 64'(m[63:32]));
        chk({tag, " lo"},      64'(bus.lo), 64'(m[31:0]));
        chk({tag, " dz"},      64'(bus.dz_flag), 64'(m[64]));
        @(negedge CLK);
        chk({tag, " idle busy"}, 64'(bus.busy), 64'd0);
        chk({tag, " idle done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          n;
        int          bcnt;
        int          dseen;
        logic [31:0] a;
        logic [31:0] b;
        muldiv_op_t  o;

        nRST       = 1'b0;
        bus.start  = 1'b0;
        bus.op     = MD_MULT;
        bus.porta  = '0;
        bus.portb  = '0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        bus.wdata  = '0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset dz",   64'(bus.dz_flag), 64'd0);
        chk("reset hi",   64'(bus.hi), 64'd0);
        chk("reset lo",   64'(bus.lo), 64'd0);

        run_check("mult -2*3",   MD_MULT,  32'hFFFF_FFFE, 32'd3);
        chk("mult -2*3 hi const", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult -2*3 lo const", 64'(bus.lo), 64'hFFFF_FFFA);
        run_check("multu max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu max hi const", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu max lo const", 64'(bus.lo), 64'h0000_0001);
        run_check("div -7/2",    MD_DIV,   32'hFFFF_FFF9, 32'd2);
        chk("div -7/2 lo const", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div -7/2 hi const", 64'(bus.hi), 64'hFFFF_FFFF);
        run_check("divu 7/2",    MD_DIVU,  32'd7, 32'd2);
        run_check("div wrap",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        chk("div wrap lo const", 64'(bus.lo), 64'h8000_0000);
        run_check("div 5/0",     MD_DIV,   32'd5, 32'd0);
        chk("div 5/0 hi const",  64'(bus.hi), 64'd5);

        // dz_flag clears on the next accepted start.
        issue(MD_MULT, 32'd2, 32'd3);
        chk("dz clear on start", 64'(bus.dz_flag), 64'd0);
        wait_done(n, bcnt);
        chk("dz clear mult lo", 64'(bus.lo), 64'd6);
        @(negedge CLK);

        // Reset in the middle of CALC discards the operation.
        issue(MD_MULT, 32'd3, 32'd4);
        repeat (9) @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset hi",   64'(bus.hi), 64'd0);
        chk("midreset lo",   64'(bus.lo), 64'd0);
        chk("midreset done", 64'(bus.done), 64'd0);
        nRST  = 1'b1;
        dseen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.done === 1'b1) dseen++;
        end
        chk("midreset no done", 64'(dseen), 64'd0);

        // Direct HI/LO writes while idle.
        @(negedge CLK);
        bus.hi_wen = 1'b1;
        bus.lo_wen = 1'b1;
        bus.wdata  = 32'hA5A5_A5A5;
        @(negedge CLK);
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        chk("mthi", 64'(bus.hi), 64'hA5A5_A5A5);
        chk("mtlo", 64'(bus.lo), 64'hA5A5_A5A5);

        // Start with a simultaneous hi write: start wins.
        @(negedge CLK);
        bus.start  = 1'b1;
        bus.op     = MD_MULTU;
        bus.porta  = 32'd6;
        bus.portb  = 32'd7;
        bus.hi_wen = 1'b1;
        bus.wdata  = 32'hDEAD_BEEF;
        @(negedge CLK);
        bus.start  = 1'b0;
        bus.hi_wen = 1'b0;
        chk("start beats mthi", 64'(bus.hi), 64'hA5A5_A5A5);
        repeat (3) @(negedge CLK);
        // Second start and mtlo while busy are both ignored.
        bus.start  = 1'b1;
        bus.op     = MD_DIVU;
        bus.porta  = 32'd100;
        bus.portb  = 32'd3;
        bus.lo_wen = 1'b1;
        bus.wdata  = 32'h0000_1234;
        @(negedge CLK);
        bus.start  = 1'b0;
        bus.lo_wen = 1'b0;
        chk("busy mtlo lo", 64'(bus.lo), 64'hA5A5_A5A5);
        chk("busy calc hi", 64'(bus.hi), 64'hA5A5_A5A5);
        wait_done(n, bcnt);
        chk("busy first op lo", 64'(bus.lo), 64'd42);
        chk("busy first op hi", 64'(bus.hi), 64'd0);
        @(negedge CLK);
        chk("busy 2nd start dropped", 64'(bus.busy), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            o = muldiv_op_t'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
            run_check($sformatf("rand%0d op%0d", i, o), o, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
